// File: rtl/top3_tracker_if.sv
// Score-stream, dedup-handshake and emit signals of the top-3 tracker.
// The o_conf signal exists only when TOP3_TRACKER_CONF_EN is defined.
interface top3_tracker_if #(
  parameter int SCORE_W = 16
);
  logic               i_valid;
  logic [SCORE_W-1:0] i_score;
  logic               i_last;
  logic               o_ready;
  logic [4:0]         o_tops      [0:2];
  logic [4:0]         o_prev_tops [0:2];
  logic               o_next;
  logic               i_dedup_next;
  logic               o_valid;
  logic [4:0]         o_class;
`ifdef TOP3_TRACKER_CONF_EN
  logic [SCORE_W-1:0] o_conf;
`endif

  modport slave (
    input  i_valid, i_score, i_last, i_dedup_next,
`ifdef TOP3_TRACKER_CONF_EN
    output o_conf,
`endif
    output o_ready, o_tops, o_prev_tops, o_next, o_valid, o_class
  );

  modport master (
    output i_valid, i_score, i_last, i_dedup_next,
`ifdef TOP3_TRACKER_CONF_EN
    input  o_conf,
`endif
    input  o_ready, o_tops, o_prev_tops, o_next, o_valid, o_class
  );
endinterface

// File: rtl/top3_tracker.sv
// Ranks per-window classifier scores into a top-3, asks the dedup stage for a
// verdict and emits the winner when new. TOP3_TRACKER_CONF_EN adds o_conf.
//
// state     | meaning
// S_COLLECT | accepting score beats, ranking into three slots
// S_REQ     | one-cycle o_next request to the dedup stage
// S_WAIT    | DEDUP_WAIT-cycle verdict window, latch any i_dedup_next
// S_EMIT    | o_valid strobe, commit current top-3 as previous
module top3_tracker #(
  parameter int NUM_CLASSES = 20,
  parameter int SCORE_W     = 16,
  parameter int DEDUP_WAIT  = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  top3_tracker_if.slave  bus
);
  localparam int WW = (DEDUP_WAIT < 2) ? 1 : $clog2(DEDUP_WAIT);

  typedef enum logic [1:0] {S_COLLECT, S_REQ, S_WAIT, S_EMIT} state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [WW-1:0]      wait_q, wait_d;
  logic               flag_q, flag_d;
  logic [2:0]         slot_v_q, slot_v_d;
  logic [4:0]         slot_idx_q [3];
  logic [4:0]         slot_idx_d [3];
  logic [SCORE_W-1:0] slot_sc_q  [3];
  logic [SCORE_W-1:0] slot_sc_d  [3];
  logic [4:0]         prev_q [3];
  logic [4:0]         prev_d [3];
  logic               valid_q, valid_d;
  logic [4:0]         class_q, class_d;
  logic [SCORE_W-1:0] conf_q, conf_d;
  logic [4:0]         tops [3];
  logic               beat, rankable, ins0, ins1, ins2;

  always_comb begin
    for (int k = 0; k < 3; k++) tops[k] = slot_v_q[k] ? slot_idx_q[k] : 5'd31;
  end

  assign beat     = bus.i_valid && (state_q == S_COLLECT);
  assign rankable = (cnt_q < 5'(NUM_CLASSES));
  // Strict compare: an equal score never displaces an earlier index.
  assign ins0 = !slot_v_q[0] || (bus.i_score > slot_sc_q[0]);
  assign ins1 = !slot_v_q[1] || (bus.i_score > slot_sc_q[1]);
  assign ins2 = !slot_v_q[2] || (bus.i_score > slot_sc_q[2]);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    flag_d     = flag_q;
    slot_v_d   = slot_v_q;
    slot_idx_d = slot_idx_q;
    slot_sc_d  = slot_sc_q;
    prev_d     = prev_q;
    valid_d    = 1'b0;
    class_d    = class_q;
    conf_d     = conf_q;
    case (state_q)
      S_COLLECT: begin
        if (beat) begin
          if (rankable) begin
            if (ins0) begin
              slot_v_d   = {slot_v_q[1:0], 1'b1};
              slot_idx_d = '{cnt_q, slot_idx_q[0], slot_idx_q[1]};
              slot_sc_d  = '{bus.i_score, slot_sc_q[0], slot_sc_q[1]};
            end else if (ins1) begin
              slot_v_d[2:1] = {slot_v_q[1], 1'b1};
              slot_idx_d[2] = slot_idx_q[1];
              slot_sc_d[2]  = slot_sc_q[1];
              slot_idx_d[1] = cnt_q;
              slot_sc_d[1]  = bus.i_score;
            end else if (ins2) begin
              slot_v_d[2]   = 1'b1;
              slot_idx_d[2] = cnt_q;
              slot_sc_d[2]  = bus.i_score;
            end
          end
          if (bus.i_last) begin
            cnt_d   = 5'd0;
            state_d = S_REQ;
          end else if (cnt_q != 5'd31) begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_REQ: begin
        flag_d  = 1'b0;
        wait_d  = WW'(DEDUP_WAIT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_dedup_next) flag_d = 1'b1;
        if (wait_q == '0) begin
          if (flag_q || bus.i_dedup_next) begin
            state_d = S_EMIT;
            valid_d = 1'b1;
            class_d = tops[0];
            conf_d  = slot_sc_q[0];
          end else begin
            state_d  = S_COLLECT;
            slot_v_d = 3'b000;
          end
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      S_EMIT: begin
        prev_d   = tops;
        slot_v_d = 3'b000;
        state_d  = S_COLLECT;
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_COLLECT;
      cnt_q    <= '0;
      wait_q   <= '0;
      flag_q   <= 1'b0;
      slot_v_q <= '0;
      valid_q  <= 1'b0;
      class_q  <= '0;
      conf_q   <= '0;
      for (int k = 0; k < 3; k++) begin
        slot_idx_q[k] <= '0;
        slot_sc_q[k]  <= '0;
        prev_q[k]     <= 5'd31;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      flag_q     <= flag_d;
      slot_v_q   <= slot_v_d;
      slot_idx_q <= slot_idx_d;
      slot_sc_q  <= slot_sc_d;
      prev_q     <= prev_d;
      valid_q    <= valid_d;
      class_q    <= class_d;
      conf_q     <= conf_d;
    end
  end

  assign bus.o_ready        = (state_q == S_COLLECT);
  assign bus.o_next         = (state_q == S_REQ);
  assign bus.o_valid        = valid_q;
  assign bus.o_class        = class_q;
  assign bus.o_tops[0]      = tops[0];
  assign bus.o_tops[1]      = tops[1];
  assign bus.o_tops[2]      = tops[2];
  assign bus.o_prev_tops[0] = prev_q[0];
  assign bus.o_prev_tops[1] = prev_q[1];
  assign bus.o_prev_tops[2] = prev_q[2];
`ifdef TOP3_TRACKER_CONF_EN
  assign bus.o_conf         = conf_q;
`else
  logic unused_conf;
  assign unused_conf = ^conf_q;
`endif
endmodule

// File: doc/top3_tracker.md
# top3_tracker

Front end of the gesture-decision path. It consumes a per-window stream of classifier scores and ranks the top-3 class indices. It hands the current and last-emitted top-3 to the dedup stage together with a one-cycle `next` request, then collects the dedup verdict. When the dedup stage reports a genuinely new gesture, it emits the winning class downstream and commits the current top-3 as the new "previous" set.

## Interface
- `NUM_CLASSES`, default 20: classes per window; index range 0..NUM_CLASSES-1, must be ≤ 31.
- `SCORE_W`, default 16: unsigned score width.
- `DEDUP_WAIT`, default 4: verdict window length in cycles after the request pulse.

- `i_clk` in 1: the single clock for the block.
- `i_rst` in 1: reset, asynchronous and active-high.
- `i_valid` in 1: score beat valid.
- `i_score` in SCORE_W: score of class index = beat count within the window.
- `i_last` in 1: final beat of the window.
- `o_ready` in/out: out 1; high only in S_COLLECT.
- `o_tops[0:2]` out 5 each: current top-3, ranked best-first; drives the dedup `i_tops`.
- `o_prev_tops[0:2]` out 5 each: last emitted top-3; drives the dedup `i_prev_tops`.
- `o_next` out 1: one-cycle request to dedup (dedup `i_next`).
- `i_dedup_next` in 1: dedup verdict; high means "new, not duplicate".
- `o_valid` out 1: one-cycle emit strobe.
- `o_class` out 5: emitted class, equal to `o_tops[0]`, valid with `o_valid`.

## Operation
- States:
  - S_COLLECT is the reset state.
  - S_REQ.
  - S_WAIT.
  - S_EMIT.
- **S_COLLECT**
  - A beat is accepted when `i_valid & o_ready`.
  - A 5-bit index counter starts at 0 and increments per accepted beat. It saturates at 31; beats at index ≥ NUM_CLASSES are accepted but not ranked.
- **Insertion**
  - Three slots, each holding {valid, index, score}.
  - A beat enters slot k when slot k is empty or its score is strictly greater than slot k's score; lower slots shift down by one.
  - Ties keep the earlier index ranked higher.
- **Window end**
  - Accepting `i_last` moves the FSM to S_REQ.
  - The index counter clears.
  - Unfilled slots present index 5'd31.
- **S_REQ**
  - `o_next` = 1 for exactly one cycle.
  - Go to S_WAIT.
  - Clear the verdict flag and the wait counter.
- **S_WAIT**
  - Runs for DEDUP_WAIT cycles.
  - If `i_dedup_next` is high in any of these cycles, set the verdict flag.
  - At the end of the window: flag set → S_EMIT; flag clear → S_COLLECT (window discarded).
- **S_EMIT**
  - `o_valid` = 1 for one cycle with `o_class` = `o_tops[0]`.
  - `o_prev_tops` ← `o_tops`.
  - Go to S_COLLECT.
- **Returning to S_COLLECT** clears all slots.
- **Stability:** `o_tops` and `o_prev_tops` are held stable from S_REQ through the end of S_WAIT / S_EMIT. The dedup stage latches them after the request.
- `o_prev_tops` updates only in S_EMIT. A duplicate window never changes it.
- `i_dedup_next` outside S_WAIT is ignored.
- `i_valid` outside S_COLLECT is ignored and not back-pressured beyond `o_ready` = 0.

## Timing
- **Reset values:**
  - state S_COLLECT.
  - `o_ready` = 1.
  - `o_next` = 0.
  - `o_valid` = 0.
  - `o_class` = 0.
  - all slots empty.
  - `o_tops` = {31,31,31}.
  - `o_prev_tops` = {31,31,31}.
  - counters 0.
- **Request timing:** `i_last` accepted at cycle T → `o_next` high at T+1.
- **Verdict window:** cycles T+2 .. T+1+DEDUP_WAIT.
- **Emit timing:** `o_valid` at T+2+DEDUP_WAIT.
- **Next window:** `o_ready` is high again at T+3+DEDUP_WAIT. For the discard path it is high at T+2+DEDUP_WAIT.
- **Dedup latency fit:** the dedup stage answers 3 cycles after its request, which lands inside the default window of 4.
- **Reset mid-operation:** asynchronous; all state returns to reset values immediately; no `o_valid` is emitted for the interrupted window.
- **Single-beat window** (`i_valid` & `i_last` on index 0): the window is ranked and requested normally; `o_tops` = {0,31,31}.

## Configuration
- Macro: `TOP3_TRACKER_CONF_EN`.
- **Defined:**
  - Adds output `o_conf` [SCORE_W] = slot-0 score.
  - `o_conf` is registered alongside `o_class` and valid with `o_valid`.
  - `o_conf` resets to 0.
- **Not defined:** the port and its register are absent; all other behaviour is identical.

## Test plan
- **Reset:** assert `i_rst` asynchronously → `o_tops` = `o_prev_tops` = {31,31,31}; `o_ready` = 1; `o_next` = 0; `o_valid` = 0.
- **Ranking:**
  - Stimulus: 20 beats with scores 5,9,9,1,40,… (all other scores < 9), then `i_last`.
  - Required: `o_tops` = {4,1,2} with the tie resolved to the lower index; `o_next` high exactly at T+1.
- **New gesture:**
  - Stimulus: `i_dedup_next` pulsed at T+4.
  - Required: `o_valid` at T+6 with `o_class` = 4; `o_prev_tops` = {4,1,2} afterwards.
- **Duplicate:**
  - Stimulus: `i_dedup_next` stays 0 through the window.
  - Required: no `o_valid`; `o_prev_tops` unchanged; `o_ready` back high at T+6.
- **Back-pressure:** `i_valid` held high during S_REQ/S_WAIT → `o_ready` = 0 and no slot or counter change; the next window starts at index 0.
- **Reset mid-window:** pulse `i_rst` in S_WAIT while `i_dedup_next` = 1 → no `o_valid`; `o_prev_tops` = {31,31,31}.
